// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter. It uses iterative double-dabble and
//   consumes one operand bit per clock. The packed result feeds the per-digit
//   7-segment hex drivers, where bcd[4*i+3:4*i] drives digit i (digit 0 = LSD).
//   A start/done handshake controls conversions. The result stays stable from
//   one done pulse until the next.
//
// Parameters
//   IN_W     width of the binary operand (>= 4)
//   DIGITS   number of BCD digits produced (>= 1)
//
// Ports
//   clk       in   1          system clock, rising edge
//   rst_n     in   1          synchronous reset, active low
//   start     in   1          conversion request, taken only while busy == 0
//   bin       in   IN_W       operand, sampled on the edge that accepts start
//   busy      out  1          conversion in progress
//   done      out  1          one-cycle pulse when bcd/overflow/neg update
//   bcd       out  4*DIGITS   packed BCD result, held until the next done
//   overflow  out  1          value >= 10^DIGITS (bcd holds value mod 10^DIGITS)
//   neg       out  1          sign of the converted value, held with bcd
//
// Configuration
//   BIN2BCD_SIGNED_EN  When defined, bin is two's complement. The magnitude is
//                      converted and neg carries the sign. When not defined,
//                      bin is unsigned, neg is tied low and no negation logic
//                      is built.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  neg
);

  localparam int              BCD_W      = 4 * DIGITS;
  localparam int              CW         = $clog2(IN_W) + 1;
  localparam logic [CW-1:0]   LAST_COUNT = CW'(IN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [IN_W-1:0]   operand;
  logic [IN_W-1:0]   load_value;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  corrected;
  logic [BCD_W-1:0]  scratch_next;
  logic              sticky;
  logic              shift_out;
  logic [CW-1:0]     count;
  logic              accept;
  logic              last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (count == LAST_COUNT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. SHIFT runs exactly IN_W cycles (count 0..IN_W-1).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == LAST_COUNT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. busy is a pure function of the registered state.
  always_comb begin
    busy = 1'b0;
    if (state == SHIFT) busy = 1'b1;
  end

  // Double-dabble correction. Each digit >= 5 gets +3 before the shift, so
  // the doubled digit carries correctly into the next digit. Each digit is
  // corrected independently, with no carry between digits.
  always_comb begin
    corrected = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // A bit leaving the top digit means the value has passed 10^DIGITS.
  // The remaining digits still form value mod 10^DIGITS.
  assign shift_out    = corrected[BCD_W-1];
  assign scratch_next = {corrected[BCD_W-2:0], operand[IN_W-1]};

`ifdef BIN2BCD_SIGNED_EN
  // The magnitude is taken in IN_W bits. The most negative value maps to
  // 2^(IN_W-1), which is correct when read as unsigned.
  assign load_value = bin[IN_W-1] ? (~bin + {{(IN_W-1){1'b0}}, 1'b1}) : bin;
`else
  assign load_value = bin;
`endif

  // Conversion datapath and result registers. The result registers load only
  // on the final shift, so intermediate scratch values never appear on bcd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      operand  <= '0;
      scratch  <= '0;
      sticky   <= 1'b0;
      count    <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        operand <= load_value;
        scratch <= '0;
        sticky  <= 1'b0;
        count   <= '0;
      end else if (state == SHIFT) begin
        operand <= {operand[IN_W-2:0], 1'b0};
        scratch <= scratch_next;
        sticky  <= sticky | shift_out;
        count   <= count + CW'(1);
        if (last_step) begin
          bcd      <= scratch_next;
          overflow <= sticky | shift_out;
          done     <= 1'b1;
        end
      end
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  logic neg_pending;

  // The sign is captured at accept time and published together with the
  // result, so neg never changes ahead of bcd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_pending <= 1'b0;
      neg         <= 1'b0;
    end else begin
      if (accept) neg_pending <= bin[IN_W-1];
      if (last_step) neg <= neg_pending;
    end
  end
`else
  assign neg = 1'b0;
`endif

  // A done pulse always coincides with the return to idle.
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);

  // Every published digit is a legal decimal digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit_chk
    a_digit_valid: assert property (@(posedge clk) disable iff (!rst_n) bcd[4*g +: 4] <= 4'd9);
  end

endmodule
